// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - sequential shift-add 32x32->64 unsigned multiply sharing the execution-stage ALU
// Optional build macro: MUL_EARLY_EXIT_EN (stops iterating once the remaining multiplier bits are all zero)
module alu_mul_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_hi,
  output logic [DATA_WIDTH-1:0] out_lo,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_carryout
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [2:0]       OP_ADD   = 3'b010;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_acc_hi;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_hi;
  logic [DATA_WIDTH-1:0] r_out_lo;

  // One shift-add step: the full 33-bit sum shifts right into {acc_hi, mplier},
  // so the ALU carry lands in the top bit of acc_hi rather than being dropped.
  logic [DATA_WIDTH-1:0] w_step_hi;
  logic [DATA_WIDTH-1:0] w_step_lo;
  assign w_step_hi = {alu_carryout, alu_result[DATA_WIDTH-1:1]};
  assign w_step_lo = {alu_result[0], r_mplier[DATA_WIDTH-1:1]};

`ifdef MUL_EARLY_EXIT_EN
  // Remaining multiplier bits; once zero, every further step would only shift.
  logic [DATA_WIDTH-1:0]   r_mrem;
  logic                    w_exit;
  logic [CNT_W:0]          w_shamt;
  logic [2*DATA_WIDTH-1:0] w_aligned;
  assign w_exit    = (r_mrem == '0);
  assign w_shamt   = (CNT_W+1)'(DATA_WIDTH) - {1'b0, r_cnt};
  assign w_aligned = {r_acc_hi, r_mplier} >> w_shamt;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_hi    = r_out_hi;
  assign out_lo    = r_out_lo;

  // ALU drive: accumulate during CALC, park at ADD 0+0 otherwise
  always_comb begin
    alu_op = OP_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (r_state == S_CALC) begin
      alu_a = r_acc_hi;
      alu_b = r_mplier[0] ? r_mcand : '0;
    end
  end

  // Control FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc_hi    <= '0;
      r_mplier    <= '0;
      r_mcand     <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_hi    <= '0;
      r_out_lo    <= '0;
`ifdef MUL_EARLY_EXIT_EN
      r_mrem      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand    <= in_a;
            r_mplier   <= in_b;
            r_acc_hi   <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_CALC;
`ifdef MUL_EARLY_EXIT_EN
            r_mrem     <= in_b;
`endif
          end
        end
        S_CALC: begin
`ifdef MUL_EARLY_EXIT_EN
          if (w_exit) begin
            r_acc_hi    <= w_aligned[2*DATA_WIDTH-1:DATA_WIDTH];
            r_mplier    <= w_aligned[DATA_WIDTH-1:0];
            r_out_hi    <= w_aligned[2*DATA_WIDTH-1:DATA_WIDTH];
            r_out_lo    <= w_aligned[DATA_WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else
`endif
          begin
            r_acc_hi <= w_step_hi;
            r_mplier <= w_step_lo;
            r_cnt    <= r_cnt + 1'b1;
`ifdef MUL_EARLY_EXIT_EN
            r_mrem   <= r_mrem >> 1;
`endif
            if (r_cnt == LAST_CNT) begin
              r_out_hi    <= w_step_hi;
              r_out_lo    <= w_step_lo;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - directed-vector bench for alu_mul_seq with a behavioural ALU
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_carryout;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  // combinational ALU: only ADD is needed by the multiplier
  assign {alu_carryout, alu_result} = (alu_op == 3'b010) ? ({1'b0, alu_a} + {1'b0, alu_b}) : 33'd0;

  alu_mul_seq dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_hi       (out_hi),
    .out_lo       (out_lo),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carryout (alu_carryout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // cycles from accept edge t to first out_valid, counted as t+N
  function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int msb;
    if (b == 32'd0) return 2;
    if (b[31]) return 33;
    msb = 0;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    return msb + 3;
`else
    return 33;
`endif
  endfunction

  task automatic wait_valid(input string tag, input int exp);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n + 1), 64'(exp));
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp_p,
                     input int hold, input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    chk({tag, "_busy"}, 64'(in_ready), 64'd0);
    // a competing request stays asserted while the product is held
    in_valid = (hold > 0);
    in_a     = 32'hDEADBEEF;
    in_b     = 32'h00000003;
    wait_valid(tag, exp_lat(b));
    chk({tag, "_prod"}, {out_hi, out_lo}, exp_p);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
      end
      chk({tag, "_hold_prod"}, {out_hi, out_lo}, exp_p);
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_after_rdy"}, 64'(in_ready), 64'd1);
    chk({tag, "_after_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", {out_hi, out_lo}, 64'd0);
    chk("rst_alu", {29'd0, alu_op, alu_a}, {29'd0, 3'b010, 32'd0});
    rst = 1'b0;
    @(posedge clk); #1;

    run(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, "t1_3x5");
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0, "t2_max");
    run(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E_242D2080, 10, "t3_hold");

    // abort during CALC iteration 10
    in_a = 32'h0000ABCD; in_b = 32'h0000FFFF; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_calc_op", {29'd0, alu_op, alu_a}, {29'd0, 3'b010, alu_a});
    chk("t4_calc_rdy", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("t4_abort_rdy", 64'(in_ready), 64'd1);
    chk("t4_abort_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1'b1;
      end
      chk("t4_no_valid", 64'(seen), 64'd0);
    end
    run(32'd7, 32'd6, 64'd42, 0, "t4_7x6");

    // back-to-back with in_valid held high
    in_a = 32'd100; in_b = 32'd200; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_a = 32'h80000001; in_b = 32'd3;
    wait_valid("t5_first", exp_lat(32'd200));
    chk("t5_first_prod", {out_hi, out_lo}, 64'd20000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_gap_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("t5_second_acc", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_valid("t5_second", exp_lat(32'd3));
    chk("t5_second_prod", {out_hi, out_lo}, 64'h00000001_80000003);
    @(posedge clk); #1;
    chk("t5_end_rdy", 64'(in_ready), 64'd1);

    run(32'h00001234, 32'd0, 64'd0, 0, "t6_b0");
    run(32'h00000010, 32'd5, 64'h50, 0, "t6_10x5");
    run(32'd2, 32'h80000000, 64'h00000001_00000000, 0, "t6_msb");
    run(32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 0, "t6_b1");
    run(32'h0, 32'h7FFFFFFF, 64'd0, 0, "t6_a0");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
